// File: rtl/shift_sched_pkg.sv
// Shared state encoding and constants for the shift_sched byte serialiser.
package shift_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StParity,
        StDone
    } state_e;

    localparam logic        LEFT     = 1'b1;
    localparam logic        RIGHT    = 1'b0;
    localparam int unsigned BitCount = 8;

endpackage

// File: rtl/shift_sched_if.sv
// Requester / serial-output bundle for shift_sched; i_/o_ are named from the scheduler's side.
interface shift_sched_if;
    import shift_sched_pkg::*;

    logic                i_en;
    logic                i_req0_valid;
    logic                i_req1_valid;
    logic [BitCount-1:0] i_req0_data;
    logic [BitCount-1:0] i_req1_data;
    logic                i_req0_dir;
    logic                i_req1_dir;
    logic                o_req0_ready;
    logic                o_req1_ready;
    logic                o_sdo;
    logic                o_bit_stb;
    logic                o_busy;
    logic                o_gnt;
    logic                o_frame_done;

    modport master (
        output i_en, i_req0_valid, i_req1_valid, i_req0_data, i_req1_data,
               i_req0_dir, i_req1_dir,
        input  o_req0_ready, o_req1_ready, o_sdo, o_bit_stb, o_busy, o_gnt, o_frame_done
    );

    modport slave (
        input  i_en, i_req0_valid, i_req1_valid, i_req0_data, i_req1_data,
               i_req0_dir, i_req1_dir,
        output o_req0_ready, o_req1_ready, o_sdo, o_bit_stb, o_busy, o_gnt, o_frame_done
    );

endinterface

// File: rtl/shift_core8.sv
// 8-bit load/shift register with selectable bit order and the serial output mux.
module shift_core8
    import shift_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [BitCount-1:0] i_data,
    input  logic                i_shift,
    input  logic                i_dir,
    input  logic                i_sdo_en,
    input  logic                i_par_sel,
    output logic                o_sdo
);

    logic [BitCount-1:0] r_sr;
    logic                r_par;
    logic                w_bit;

    // Parity is taken at load time; the register itself is zero after eight shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_par <= 1'b0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_par <= ^i_data;
        end else if (i_shift) begin
            if (i_dir == LEFT) begin
                r_sr <= {r_sr[BitCount-2:0], 1'b0};
            end else begin
                r_sr <= {1'b0, r_sr[BitCount-1:1]};
            end
        end
    end

    always_comb begin
        w_bit = (i_dir == LEFT) ? r_sr[BitCount-1] : r_sr[0];
        o_sdo = 1'b0;
        if (i_sdo_en) begin
            o_sdo = i_par_sel ? r_par : w_bit;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin byte serialiser: FSM, arbiter, prescaler and bit counter.
// Define SHIFT_SCHED_PARITY_EN to append an even-parity bit after the eighth data bit.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input logic          clk,
    input logic          rst,
    shift_sched_if.slave bus
);

    localparam logic [7:0] PrescMax = 8'(DIV - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [7:0]          r_presc;
    logic [2:0]          r_bit_cnt;
    logic                r_gnt;
    logic                r_prio;
    logic [BitCount-1:0] r_data;
    logic                r_dir;

    logic                w_any;
    logic                w_win;
    logic                w_accept;
    logic                w_in_bit;
    logic                w_stb;
    logic                w_last_bit;

    // w_win = 1 selects requester 1; r_prio names whoever wins a tie.
    assign w_any      = bus.i_req0_valid | bus.i_req1_valid;
    assign w_win      = (bus.i_req0_valid & bus.i_req1_valid) ? r_prio : bus.i_req1_valid;
    assign w_accept   = (r_state == StIdle) & bus.i_en & w_any & ~rst;
    assign w_in_bit   = (r_state == StShift) | (r_state == StParity);
    assign w_stb      = bus.i_en & w_in_bit & (r_presc == PrescMax);
    assign w_last_bit = (r_bit_cnt == 3'(BitCount - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.i_en) begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        w_state_next = StLoad;
                    end
                end
                StLoad: w_state_next = StShift;
                StShift: begin
`ifdef SHIFT_SCHED_PARITY_EN
                    if (w_stb && w_last_bit) begin
                        w_state_next = StParity;
                    end
`else
                    if (w_stb && w_last_bit) begin
                        w_state_next = StDone;
                    end
`endif
                end
                StParity: begin
                    if (w_stb) begin
                        w_state_next = StDone;
                    end
                end
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_bit_cnt <= '0;
            r_gnt     <= 1'b0;
            r_prio    <= 1'b0;
            r_data    <= '0;
            r_dir     <= RIGHT;
        end else if (bus.i_en) begin
            if (w_in_bit) begin
                r_presc <= w_stb ? 8'd0 : r_presc + 8'd1;
            end
            if (w_stb && (r_state == StShift)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_accept) begin
                r_gnt  <= w_win;
                r_prio <= ~w_win;
                r_data <= w_win ? bus.i_req1_data : bus.i_req0_data;
                r_dir  <= w_win ? bus.i_req1_dir : bus.i_req0_dir;
            end
        end
    end

    shift_core8 u_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (bus.i_en & (r_state == StLoad)),
        .i_data    (r_data),
        .i_shift   (w_stb & (r_state == StShift)),
        .i_dir     (r_dir),
        .i_sdo_en  (w_in_bit),
        .i_par_sel (r_state == StParity),
        .o_sdo     (bus.o_sdo)
    );

    assign bus.o_req0_ready = w_accept & ~w_win;
    assign bus.o_req1_ready = w_accept & w_win;
    assign bus.o_bit_stb    = w_stb;
    assign bus.o_busy       = (r_state != StIdle);
    assign bus.o_gnt        = r_gnt;
    assign bus.o_frame_done = bus.i_en & (r_state == StDone);

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: vector table of frames plus freeze, reset and DIV=1 sequences.
module tb_shift_sched;

    localparam int DIV = 4;
`ifdef SHIFT_SCHED_PARITY_EN
    localparam int NBits = 9;
`else
    localparam int NBits = 8;
`endif
    localparam int FrameLen = NBits * DIV + 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    shift_sched_if bus ();
    shift_sched_if bus1 ();

    shift_sched #(.DIV(DIV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    shift_sched #(.DIV(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       dir0;
        logic       dir1;
        logic       drop;
        logic       exp_gnt;
        logic [7:0] exp_seq;  // bits in transmission order, first bit at [7]
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_accept(input logic g);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.o_req0_ready || bus.o_req1_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("accept_seen", 32'(got), 32'd1);
        if (got) begin
            chk("ready0", 32'(bus.o_req0_ready), 32'(!g));
            chk("ready1", 32'(bus.o_req1_ready), 32'(g));
        end
    endtask

    // Called in the accept cycle; p counts enabled cycles since accept.
    task automatic do_frame(input logic g, input logic [7:0] seq, input logic par,
                            input int fs, input int fl, input logic drop);
        int   p;
        int   c;
        bit   done;
        logic en_prev;
        logic in_bits;
        logic exp_sdo;
        p       = 0;
        c       = 0;
        done    = 1'b0;
        en_prev = 1'b1;
        while (!done && c < FrameLen + fl + 10) begin
            @(negedge clk);
            c++;
            if (en_prev) p++;
            if (drop && c == 1) begin
                bus.i_req0_valid = 1'b0;
                bus.i_req1_valid = 1'b0;
                bus.i_req0_data  = ~bus.i_req0_data;
                bus.i_req1_data  = ~bus.i_req1_data;
            end
            bus.i_en = !(c >= fs && c < fs + fl);
            #1;
            if (p >= FrameLen) begin
                chk("busy_idle", 32'(bus.o_busy), 32'd0);
                chk("sdo_idle", 32'(bus.o_sdo), 32'd0);
                chk("frame_cycles", 32'(c), 32'(FrameLen + fl));
                done = 1'b1;
            end else begin
                in_bits = (p >= 2) && (p < 2 + NBits * DIV);
                if (p >= 2 && p < 2 + 8 * DIV) exp_sdo = seq[7 - (p - 2) / DIV];
                else if (in_bits) exp_sdo = par;
                else exp_sdo = 1'b0;
                chk("sdo", 32'(bus.o_sdo), 32'(exp_sdo));
                chk("bit_stb", 32'(bus.o_bit_stb),
                    32'(bus.i_en && in_bits && ((p - 2) % DIV == DIV - 1)));
                chk("frame_done", 32'(bus.o_frame_done), 32'(bus.i_en && p == FrameLen - 1));
                chk("busy", 32'(bus.o_busy), 32'd1);
                chk("gnt", 32'(bus.o_gnt), 32'(g));
                chk("ready_busy", 32'(bus.o_req0_ready | bus.o_req1_ready), 32'd0);
            end
            en_prev = bus.i_en;
        end
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
        bus.i_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got1;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'hA5, 8'h1B, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD8};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 8'h1B, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 8'h55, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80};
        vecs[4] = '{1'b0, 1'b1, 8'h55, 8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 8'h69};
        vecs[5] = '{1'b1, 1'b0, 8'hF0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F};
        vecs[6] = '{1'b1, 1'b1, 8'h3C, 8'hE1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hE1};

        rst               = 1'b1;
        bus.i_en          = 1'b1;
        bus.i_req0_valid  = 1'b1;
        bus.i_req1_valid  = 1'b1;
        bus.i_req0_data   = 8'hFF;
        bus.i_req1_data   = 8'hFF;
        bus.i_req0_dir    = 1'b1;
        bus.i_req1_dir    = 1'b1;
        bus1.i_en         = 1'b1;
        bus1.i_req0_valid = 1'b0;
        bus1.i_req1_valid = 1'b0;
        bus1.i_req0_data  = 8'h00;
        bus1.i_req1_data  = 8'h00;
        bus1.i_req0_dir   = 1'b0;
        bus1.i_req1_dir   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", 32'(bus.o_req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.o_req1_ready), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_sdo", 32'(bus.o_sdo), 32'd0);
        chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
        chk("rst_stb", 32'(bus.o_bit_stb), 32'd0);
        chk("rst_fd", 32'(bus.o_frame_done), 32'd0);
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table of frames on the DIV=4 instance.
        for (int i = 0; i < 7; i++) begin
            bus.i_req0_valid = vecs[i].v0;
            bus.i_req1_valid = vecs[i].v1;
            bus.i_req0_data  = vecs[i].d0;
            bus.i_req1_data  = vecs[i].d1;
            bus.i_req0_dir   = vecs[i].dir0;
            bus.i_req1_dir   = vecs[i].dir1;
            wait_accept(vecs[i].exp_gnt);
            do_frame(vecs[i].exp_gnt, vecs[i].exp_seq,
                     ^(vecs[i].exp_gnt ? vecs[i].d1 : vecs[i].d0), 0, 0, vecs[i].drop);
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;

        // Enable held low for 5 cycles inside bit 3.
        bus.i_req0_valid = 1'b1;
        bus.i_req0_data  = 8'hA5;
        bus.i_req0_dir   = 1'b1;
        wait_accept(1'b0);
        do_frame(1'b0, 8'hA5, 1'b0, 15, 5, 1'b1);

        // Reset during bit 5 of a frame that requester 1 won.
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        bus.i_req0_data  = 8'h5A;
        bus.i_req1_data  = 8'hC3;
        bus.i_req0_dir   = 1'b1;
        bus.i_req1_dir   = 1'b1;
        wait_accept(1'b1);
        repeat (23) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_sdo", 32'(bus.o_sdo), 32'd0);
        chk("mid_rst_stb", 32'(bus.o_bit_stb), 32'd0);
        chk("mid_rst_fd", 32'(bus.o_frame_done), 32'd0);
        chk("mid_rst_gnt", 32'(bus.o_gnt), 32'd0);
        chk("mid_rst_ready", 32'(bus.o_req0_ready | bus.o_req1_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_hold_fd", 32'(bus.o_frame_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_accept(1'b0);
        do_frame(1'b0, 8'h5A, 1'b0, 0, 0, 1'b1);

        // DIV=1 instance: requester 1, 0x01 LSB first.
        bus1.i_req1_valid = 1'b1;
        bus1.i_req1_data  = 8'h01;
        bus1.i_req1_dir   = 1'b0;
        got1 = 1'b0;
        for (int i = 0; i < 20 && !got1; i++) begin
            #1;
            if (bus1.o_req1_ready) got1 = 1'b1;
            else @(negedge clk);
        end
        chk("div1_accept", 32'(got1), 32'd1);
        chk("div1_ready0", 32'(bus1.o_req0_ready), 32'd0);
        for (int c = 1; c <= NBits + 3; c++) begin
            @(negedge clk);
            if (c == 1) bus1.i_req1_valid = 1'b0;
            #1;
            chk("div1_sdo", 32'(bus1.o_sdo), 32'((c == 2) || (NBits == 9 && c == 10)));
            chk("div1_stb", 32'(bus1.o_bit_stb), 32'(c >= 2 && c < 2 + NBits));
            chk("div1_fd", 32'(bus1.o_frame_done), 32'(c == NBits + 2));
            chk("div1_busy", 32'(bus1.o_busy), 32'(c < NBits + 3));
            chk("div1_gnt", 32'(bus1.o_gnt), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter DIV, default 4, SHALL set the bit period in CLK cycles; the legal range is 1..255.
REQ-002 CLK  in  1  system clock, 100 MHz; all logic SHALL be on the rising edge.
REQ-003 RST  in  1  asynchronous reset, active-high, SHALL act without CLK.
REQ-004 EN  in  1  global enable; 0 SHALL freeze the block.
REQ-005 REQ0_VALID / REQ1_VALID  in  1 each  requester has a byte to send.
REQ-006 REQ0_DATA / REQ1_DATA  in  8 each  byte to serialise.
REQ-007 REQ0_DIR / REQ1_DIR  in  1 each  bit order: 1 = MSB first (left), 0 = LSB first (right).
REQ-008 REQ0_READY / REQ1_READY  out  1 each  one-cycle accept strobe.
REQ-009 SDO  out  1  serial data, normal polarity.
REQ-010 BIT_STB  out  1  one-cycle pulse on the last cycle of each bit period.
REQ-011 BUSY  out  1  high in every state except IDLE.
REQ-012 GNT  out  1  index of the requester owning the current frame.
REQ-013 FRAME_DONE  out  1  one-cycle pulse at end of frame.

Function
REQ-014 States: IDLE, LOAD, SHIFT, PARITY, DONE.
- IDLE->LOAD on accept.
- LOAD->SHIFT unconditionally.
- SHIFT->PARITY or DONE after bit 7.
- PARITY->DONE after one bit period.
- DONE->IDLE unconditionally.
REQ-015 Accept SHALL occur in IDLE when EN=1 and at least one VALID=1; READY of the winner SHALL be high that cycle only; DATA and DIR SHALL be captured on that edge.
REQ-016 Arbitration SHALL be round-robin: with both VALID high, the requester not granted last wins; after reset requester 0 has priority.
REQ-017 A lone VALID SHALL win regardless of priority; READY SHALL never be asserted outside IDLE.
REQ-018 LOAD SHALL parallel-load the captured byte into the shift register; SDO SHALL show the first bit from the first SHIFT cycle.
REQ-019 Latency: accept at cycle t; bit k SHALL be on SDO over cycles t+2+k*DIV .. t+1+(k+1)*DIV.
REQ-020 The shift register SHALL shift toward the output end, zero-fill, when BIT_STB fires.
REQ-021 A 3-bit counter SHALL count bits 0..7; the prescaler SHALL count 0..DIV-1 and wrap; DIV=1 SHALL give BIT_STB every SHIFT cycle.
REQ-022 DONE SHALL last one cycle with FRAME_DONE=1 and SDO=0; the next accept SHALL be possible in the following IDLE cycle.
REQ-023 EN=0 in any state SHALL hold the state, prescaler, counter, shift register and SDO; BIT_STB, READY and FRAME_DONE SHALL be 0 while EN=0.
REQ-024 SDO SHALL be 0 in IDLE, LOAD and DONE; GNT SHALL hold its last value until the next accept.
REQ-025 VALID dropping mid-frame SHALL have no effect on the frame in flight.

Reset
REQ-026 RST=1 SHALL immediately force IDLE, clear the shift register, prescaler and bit counter, set priority to requester 0, and drive all outputs 0.
REQ-027 Reset mid-frame SHALL discard the frame with no FRAME_DONE pulse.

Configuration
REQ-028 With SHIFT_SCHED_PARITY_EN defined, SHIFT SHALL go to PARITY after bit 7, and SDO SHALL carry even parity (XOR of the 8 data bits) for DIV cycles with one BIT_STB.
REQ-029 Without SHIFT_SCHED_PARITY_EN, PARITY SHALL be unreachable and SHIFT SHALL go directly to DONE; frame length SHALL be 8*DIV+3 cycles from accept to IDLE.

Structure
REQ-030 Package shift_sched_pkg SHALL hold:
- the state enum;
- the LEFT=1 and RIGHT=0 direction constants;
- the bit-count constant 8.
REQ-031 Sub-module shift_core8 SHALL hold the datapath: 8-bit register with load, shift-enable and direction inputs, plus the serial output mux. shift_sched SHALL hold the FSM, arbiter, prescaler and counter.

Verification
REQ-032 DIV=4, REQ0 sends 0xA5 with DIR=1 -> READY0 pulse at t; SDO=1,0,1,0,0,1,0,1, each held 4 cycles, from t+2; FRAME_DONE at t+34.
REQ-033 DIV=1, REQ1 sends 0x01 with DIR=0 -> SDO=1 at t+2, then 0 for 7 cycles; BIT_STB high for 8 consecutive cycles.
REQ-034 Both VALID held high, three frames -> GNT sequence 0,1,0; READY never asserted while BUSY=1.
REQ-035 EN=0 for 5 cycles during bit 3 -> SDO, BIT_STB and the counter frozen; frame end delayed by exactly 5 cycles.
REQ-036 RST pulse during bit 5 -> outputs 0 within the same cycle, no FRAME_DONE; the next frame is granted to requester 0.
REQ-037 With SHIFT_SCHED_PARITY_EN, 0x07 sent -> parity bit 1 after bit 7; FRAME_DONE at t+2+9*DIV.
